// File: rtl/reg_pkg.sv
// Shared definitions for the datapath holding registers.
package reg_pkg;

  localparam int REG_DEFAULT_WIDTH = 7;

  typedef logic [REG_DEFAULT_WIDTH-1:0] reg_word_t;

  localparam reg_word_t REG_RESET_ZERO = 7'b000_0000;

endpackage : reg_pkg

// File: rtl/dff_en.sv
// Single-bit D flip-flop with load enable and asynchronous active-high reset.
module dff_en #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic q
);

  // Storage bit: reset dominates, otherwise load on enable or hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule : dff_en

// File: rtl/reg7.sv
// Parameterised enabled storage register built from dff_en cells.
// Optional even-parity protection is enabled by defining REG7_PARITY_EN.
module reg7
  import reg_pkg::*;
#(
  parameter int                 WIDTH     = REG_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]   RESET_VAL = WIDTH'(REG_RESET_ZERO)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
`ifdef REG7_PARITY_EN
  ,
  output logic             q_par,
  output logic             par_err
`endif
);

  // One independent cell per data bit; each takes its own reset value.
  for (genvar i = 0; i < WIDTH; i++) begin : gen_bits
    dff_en #(
      .RST_VAL (RESET_VAL[i])
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .d     (d[i]),
      .q     (q[i])
    );
  end

`ifdef REG7_PARITY_EN
  function automatic logic even_par(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  logic par_d_s;

  assign par_d_s = even_par(d);

  // Parity cell shares reset/enable with the data cells so it always tracks q.
  dff_en #(
    .RST_VAL (even_par(RESET_VAL))
  ) u_par (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .d     (par_d_s),
    .q     (q_par)
  );

  assign par_err = even_par(q) ^ q_par;
`endif

endmodule : reg7

// File: tb/tb_reg7.sv
// Self-checking bench for reg7: directed scenarios plus randomized traffic
// compared against a behavioural model of the register.
module tb_reg7;

  logic       clk;
  logic       reset;
  logic       en;
  logic [6:0] d;
  logic [6:0] q;
`ifdef REG7_PARITY_EN
  logic       q_par;
  logic       par_err;
`endif

  int         errors;
  int         checks;
  logic [6:0] model_q;

  reg7 dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .d     (d),
    .q     (q)
`ifdef REG7_PARITY_EN
    ,
    .q_par   (q_par),
    .par_err (par_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Check q (and parity outputs when present) against the model.
  task automatic check_all(input string tag);
    check(tag, q, model_q);
`ifdef REG7_PARITY_EN
    check({tag, "_qpar"}, {6'd0, q_par}, {6'd0, ^model_q});
    check({tag, "_perr"}, {6'd0, par_err}, 7'd0);
`endif
  endtask

  // Apply inputs, let one rising edge pass, update model, then sample.
  task automatic step(input string tag, input logic e, input logic [6:0] dv);
    en = e;
    d  = dv;
    @(posedge clk);
    if (!reset && e) model_q = dv;
    #1;
    check_all(tag);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    model_q = 7'd0;
    reset   = 1'b0;
    en      = 1'b0;
    d       = 7'd0;

    // Reset takes effect with no clock edge.
    #2 reset = 1'b1;
    #1 check_all("reset_async");
    #19 check_all("reset_hold");

    // Load after release.
    @(negedge clk);
    reset = 1'b0;
    step("load", 1'b1, 7'b000_0001);

    // Hold across three edges.
    for (int i = 0; i < 3; i++) step("hold", 1'b0, 7'b101_0101);

    // Async reset pulse between edges, then edge while reset is high.
    step("load_ones", 1'b1, 7'b111_1111);
    #4 reset = 1'b1;
    model_q = 7'd0;
    #1 check_all("reset_mid");
    step("reset_edge", 1'b1, 7'b111_1111);

    // Reset falls 1 ns before an enabled edge.
    @(negedge clk);
    en = 1'b1;
    d  = 7'b011_0011;
    #9 reset = 1'b0;
    @(posedge clk);
    model_q = 7'b011_0011;
    #1 check_all("rel_before_edge");

`ifdef REG7_PARITY_EN
    step("par_load", 1'b1, 7'b000_0111);
    check("par_one", {6'd0, q_par}, 7'd1);
    force dut.q = model_q ^ 7'b000_0001;
    #1 check("par_forced", {6'd0, par_err}, 7'd1);
    release dut.q;
    #1 check_all("par_release");
`endif

    // Randomized traffic with occasional async reset pulses and held resets.
    for (int n = 0; n < 300; n++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        #3 reset = 1'b1;
        model_q = 7'd0;
        #1 check_all("rnd_reset_pulse");
        #2 reset = 1'b0;
      end else if (r == 1) begin
        reset = 1'b1;
        model_q = 7'd0;
        step("rnd_reset_held", 1'b1, 7'($urandom));
        #4 reset = 1'b0;
      end
      step("rnd", 1'($urandom_range(0, 1)), 7'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_reg7
